// File: rtl/score_pkg.sv
// Shared parameters and FSM state type for the score update / display path.
package score_pkg;

  localparam int DEF_SCORE_W   = 7;   // binary score width
  localparam int DEF_PTS_W     = 4;   // points-per-event width
  localparam int DEF_MAX_SCORE = 99;  // saturation ceiling, fits two BCD digits
  localparam int BCD_W         = 4;   // width of one BCD digit
  localparam int CONV_STEPS    = 7;   // shift-add-3 steps, one per score bit
  localparam int SUM_W         = 8;   // width of the saturating adder

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/score_dabble_seq.sv
// Sequential shift-add-3 binary-to-BCD engine. The start cycle performs step 0
// on the loaded snapshot, then one step per clock; done flags the cycle whose
// edge performs the final step, so ones/tens hold the result right after it.
module score_dabble_seq
  import score_pkg::*;
#(
  parameter int BIN_W = CONV_STEPS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic [BCD_W-1:0]   ones,
  output logic [BCD_W-1:0]   tens,
  output logic               done
);

  localparam int SH_W  = 2 * BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  logic [SH_W-1:0]  sh_r;
  logic [SH_W-1:0]  adj_s;
  logic [SH_W-1:0]  sh_step_s;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;

  // Add 3 to a BCD digit of 5 or more so the following shift carries correctly.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
    if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

  // One conversion step: adjust both digits, then shift the whole register left.
  always_comb begin
    adj_s     = {add3(sh_r[BIN_W+BCD_W +: BCD_W]), add3(sh_r[BIN_W +: BCD_W]), sh_r[BIN_W-1:0]};
    sh_step_s = {adj_s[SH_W-2:0], 1'b0};
  end

  // Shift register, step counter and running flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_r  <= {SH_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      run_r <= 1'b0;
    end else if (start) begin
      sh_r  <= {{(2*BCD_W-1){1'b0}}, bin, 1'b0};
      cnt_r <= CNT_W'(1);
      run_r <= 1'b1;
    end else if (run_r) begin
      sh_r  <= sh_step_s;
      cnt_r <= cnt_r + CNT_W'(1);
      run_r <= (cnt_r != LAST_STEP);
    end else begin
      sh_r  <= sh_r;
      cnt_r <= cnt_r;
      run_r <= run_r;
    end
  end

  assign ones = sh_r[BIN_W +: BCD_W];
  assign tens = sh_r[BIN_W+BCD_W +: BCD_W];
  assign done = run_r && (cnt_r == LAST_STEP);

endmodule

// File: rtl/score_update_arbiter.sv
// Round-robin arbiter sharing the player score between hit-event sources,
// with saturating add, BCD conversion of each new score and a high score.
module score_update_arbiter
  import score_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int PTS_W     = DEF_PTS_W,
  parameter int MAX_SCORE = DEF_MAX_SCORE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*PTS_W-1:0]   pts,
  output logic [N_REQ-1:0]         ack,
  input  logic                     clear,
  output logic                     busy,
  output logic [SCORE_W-1:0]       score,
  output logic [BCD_W-1:0]         ones,
  output logic [BCD_W-1:0]         tens,
  output logic                     digits_valid,
  output logic [SCORE_W-1:0]       hiscore
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_r, state_nxt;
  logic [IDX_W-1:0]   rr_r, rr_nxt;
  logic               pend_r, pend_nxt;
  logic               start_r, start_nxt;
  logic [N_REQ-1:0]   ack_r, ack_nxt;
  logic               busy_r;
  logic [SCORE_W-1:0] score_r, score_nxt;
  logic [SCORE_W-1:0] hiscore_r, hiscore_nxt;
  logic [BCD_W-1:0]   ones_r, ones_nxt;
  logic [BCD_W-1:0]   tens_r, tens_nxt;
  logic               dv_r, dv_nxt;

  logic               found_s;
  logic [IDX_W-1:0]   grant_s;
  logic [IDX_W-1:0]   rr_inc_s;
  logic [PTS_W-1:0]   pts_g_s;
  logic [SUM_W-1:0]   sum_s;
  logic [SCORE_W-1:0] sat_s;
  logic [BCD_W-1:0]   conv_ones_s;
  logic [BCD_W-1:0]   conv_tens_s;
  logic               conv_done_s;

  score_dabble_seq #(.BIN_W(SCORE_W)) u_dabble (
    .clk   (clk),
    .reset (reset),
    .start (start_r),
    .bin   (score_r),
    .ones  (conv_ones_s),
    .tens  (conv_tens_s),
    .done  (conv_done_s)
  );

  // Round-robin pick: first requesting index at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    grant_s = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_r) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req[idx]) begin
        found_s = 1'b1;
        grant_s = IDX_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Points of the granted source, saturating sum and the advanced pointer.
  always_comb begin
    pts_g_s = pts[grant_s*PTS_W +: PTS_W];
    sum_s   = SUM_W'(score_r) + SUM_W'(pts_g_s);
    if (sum_s > SUM_W'(MAX_SCORE)) begin
      sat_s = SCORE_W'(MAX_SCORE);
    end else begin
      sat_s = sum_s[SCORE_W-1:0];
    end
    if (grant_s == IDX_W'(N_REQ - 1)) begin
      rr_inc_s = {IDX_W{1'b0}};
    end else begin
      rr_inc_s = grant_s + IDX_W'(1);
    end
  end

  // Next-state and next-output logic; a clear always beats a pending request.
  always_comb begin
    state_nxt   = state_r;
    rr_nxt      = rr_r;
    pend_nxt    = pend_r;
    start_nxt   = 1'b0;
    ack_nxt     = {N_REQ{1'b0}};
    score_nxt   = score_r;
    hiscore_nxt = hiscore_r;
    ones_nxt    = ones_r;
    tens_nxt    = tens_r;
    dv_nxt      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear || pend_r) begin
          score_nxt = {SCORE_W{1'b0}};
          pend_nxt  = 1'b0;
          start_nxt = 1'b1;
          state_nxt = ST_CONV;
        end else if (found_s) begin
          ack_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << grant_s;
          score_nxt = sat_s;
          rr_nxt    = rr_inc_s;
          start_nxt = 1'b1;
          state_nxt = ST_CONV;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CONV: begin
        pend_nxt = pend_r | clear;
        if (conv_done_s) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_CONV;
        end
      end
      ST_DONE: begin
        pend_nxt = pend_r | clear;
        ones_nxt = conv_ones_s;
        tens_nxt = conv_tens_s;
        dv_nxt   = 1'b1;
        if (score_r > hiscore_r) begin
          hiscore_nxt = score_r;
        end else begin
          hiscore_nxt = hiscore_r;
        end
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rr_r      <= {IDX_W{1'b0}};
      pend_r    <= 1'b0;
      start_r   <= 1'b0;
      ack_r     <= {N_REQ{1'b0}};
      busy_r    <= 1'b0;
      score_r   <= {SCORE_W{1'b0}};
      hiscore_r <= {SCORE_W{1'b0}};
      ones_r    <= {BCD_W{1'b0}};
      tens_r    <= {BCD_W{1'b0}};
      dv_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      rr_r      <= rr_nxt;
      pend_r    <= pend_nxt;
      start_r   <= start_nxt;
      ack_r     <= ack_nxt;
      busy_r    <= (state_nxt != ST_IDLE);
      score_r   <= score_nxt;
      hiscore_r <= hiscore_nxt;
      ones_r    <= ones_nxt;
      tens_r    <= tens_nxt;
      dv_r      <= dv_nxt;
    end
  end

  assign ack          = ack_r;
  assign busy         = busy_r;
  assign score        = score_r;
  assign hiscore      = hiscore_r;
  assign ones         = ones_r;
  assign tens         = tens_r;
  assign digits_valid = dv_r;

endmodule

// File: tb/tb_score_update_arbiter.sv
// Scoreboard bench: expected score/digits/hiscore queued at each grant or
// clear, popped and compared whenever digits_valid pulses.
module tb_score_update_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  req;
  logic [15:0] pts;
  logic [3:0]  ack;
  logic        busy;
  logic [6:0]  score;
  logic [3:0]  ones;
  logic [3:0]  tens;
  logic        digits_valid;
  logic [6:0]  hiscore;

  typedef struct {
    int score;
    int tens;
    int ones;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_score  = 0;
  int   m_hi     = 0;

  score_update_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .pts          (pts),
    .ack          (ack),
    .clear        (clear),
    .busy         (busy),
    .score        (score),
    .ones         (ones),
    .tens         (tens),
    .digits_valid (digits_valid),
    .hiscore      (hiscore)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the values the next conversion must show.
  task automatic push_exp();
    exp_t e;
    if (m_score > m_hi) m_hi = m_score;
    e.score = m_score;
    e.tens  = m_score / 10;
    e.ones  = m_score % 10;
    e.hi    = m_hi;
    exp_q.push_back(e);
  endtask

  // Compare against the scoreboard on every digits_valid pulse.
  always @(negedge clk) begin
    if (!reset && digits_valid) begin
      if (exp_q.size() == 0) begin
        check("dv_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_score", score, e.score);
        check("sb_tens", tens, e.tens);
        check("sb_ones", ones, e.ones);
        check("sb_hiscore", hiscore, e.hi);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, ack, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_score"}, score, 32'd0);
    check({tag, "_digits"}, {tens, ones}, 32'd0);
    check({tag, "_dv"}, digits_valid, 32'd0);
    check({tag, "_hi"}, hiscore, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0;
    clear = 1'b0;
    tick();
    tick();
    check_zero("reset");
    reset   = 1'b0;
    m_score = 0;
    m_hi    = 0;
    exp_q.delete();
  endtask

  // One granted event: check ack, gap, score, then the 8-cycle conversion window.
  task automatic run_event(input string tag, input logic [3:0] rq, input logic [15:0] pv,
                           input logic [3:0] exp_ack, input int exp_wait, input bit clear_mid);
    int waited = 0;
    int g = 0;
    req = rq;
    pts = pv;
    do begin
      tick();
      waited++;
    end while (ack == 4'b0 && waited < 40);
    check({tag, "_ack"}, ack, exp_ack);
    if (exp_wait > 0) check({tag, "_gap"}, waited, exp_wait);
    req = rq & ~exp_ack;
    for (int i = 0; i < 4; i++) if (exp_ack[i]) g = i;
    m_score = m_score + int'(pv[g*4 +: 4]);
    if (m_score > 99) m_score = 99;
    push_exp();
    check({tag, "_score"}, score, m_score);
    check({tag, "_busy"}, busy, 32'd1);
    for (int k = 1; k <= 7; k++) begin
      if (clear_mid && k == 3) clear = 1'b1;
      tick();
      clear = 1'b0;
      check({tag, "_ack_len"}, ack, 32'd0);
      check({tag, "_dv_early"}, digits_valid, 32'd0);
      check({tag, "_busy_conv"}, busy, 32'd1);
    end
    tick();
    check({tag, "_dv_g8"}, digits_valid, 32'd1);
    check({tag, "_busy_g8"}, busy, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    clear = 1'b0;
    req   = 4'b0;
    pts   = 16'h0;

    // 1: single request on source 2
    do_reset();
    run_event("t1", 4'b0100, 16'h0500, 4'b0100, 1, 1'b0);
    req = 4'b0;
    tick();
    check("t1_dv_once", digits_valid, 32'd0);

    // 2: all sources held, round-robin from pointer 0
    do_reset();
    run_event("t2_a", 4'b1111, 16'h1111, 4'b0001, 1, 1'b0);
    run_event("t2_b", 4'b1111, 16'h1111, 4'b0010, 1, 1'b0);
    run_event("t2_c", 4'b1111, 16'h1111, 4'b0100, 1, 1'b0);
    run_event("t2_d", 4'b1111, 16'h1111, 4'b1000, 1, 1'b0);
    run_event("t2_e", 4'b1111, 16'h1111, 4'b0001, 1, 1'b0);
    req = 4'b0;

    // 3: climb to 95, saturate at 99, stay saturated
    for (int i = 0; i < 6; i++) run_event("t3_up", 4'b0001, 16'h000F, 4'b0001, 0, 1'b0);
    run_event("t3_sat", 4'b0001, 16'h0009, 4'b0001, 0, 1'b0);
    check("t3_digits", {tens, ones}, 32'h99);
    run_event("t3_hold", 4'b0001, 16'h0003, 4'b0001, 0, 1'b0);
    check("t3_score", score, 32'd99);
    req = 4'b0;

    // 4: clear during the conversion of 42
    do_reset();
    run_event("t4_a", 4'b0001, 16'h000F, 4'b0001, 0, 1'b0);
    run_event("t4_b", 4'b0001, 16'h000F, 4'b0001, 0, 1'b0);
    run_event("t4_c", 4'b0001, 16'h000C, 4'b0001, 0, 1'b1);
    req = 4'b0;
    m_score = 0;
    push_exp();
    tick();
    check("t4_clr_score", score, 32'd0);
    check("t4_clr_busy", busy, 32'd1);
    check("t4_clr_ack", ack, 32'd0);
    wait_idle("t4");
    tick();
    check("t4_hi_kept", hiscore, 32'd42);

    // 5: clear and request on the same idle edge
    clear = 1'b1;
    req   = 4'b0010;
    pts   = 16'h0070;
    tick();
    clear = 1'b0;
    check("t5_no_ack", ack, 32'd0);
    check("t5_score", score, 32'd0);
    check("t5_busy", busy, 32'd1);
    m_score = 0;
    push_exp();
    run_event("t5_req", 4'b0010, 16'h0070, 4'b0010, 9, 1'b0);
    req = 4'b0;

    // 6: reset during conversion step 3
    req = 4'b0010;
    pts = 16'h0030;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == 4'b0 && n < 40);
    check("t6_ack", ack, 32'b0010);
    req = 4'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_zero("t6_rst");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_no_dv", digits_valid, 32'd0);
    end
    m_score = 0;
    m_hi    = 0;
    run_event("t6_fresh", 4'b1000, 16'h2000, 4'b1000, 1, 1'b0);
    run_event("t6_zero_pts", 4'b1001, 16'h0000, 4'b0001, 1, 1'b0);
    req = 4'b0;
    check("t6_digits", {tens, ones}, 32'h02);

    for (int i = 0; i < 12; i++) tick();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
